// File: rtl/calcu16_fetch_queue_if.sv
// calcu16 fetch queue bus interface.
// Groups the program-memory read port, the instruction handshake toward the
// core and the redirect/halt controls. The fetch queue uses the master view;
// the memory model and core (or a testbench) use the slave view.
interface calcu16_fetch_queue_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              imem_rd;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic              instr_valid;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_ready;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halt;

  modport master (
    output imem_rd, imem_addr, instr_valid, instr, instr_pc,
    input  imem_rdata, instr_ready, redirect_valid, redirect_pc, halt
  );

  modport slave (
    input  imem_rd, imem_addr, instr_valid, instr, instr_pc,
    output imem_rdata, instr_ready, redirect_valid, redirect_pc, halt
  );
endinterface

// File: rtl/calcu16_fetch_queue.sv
// calcu16 instruction fetch queue.
// Issues word reads into a synchronous program memory (1-cycle read latency)
// and buffers returned instructions in a DEPTH-entry prefetch FIFO. Space for
// a response is reserved at issue time, so a push can never overflow.
// A redirect flushes the FIFO and restarts fetching at redirect_pc; responses
// belonging to the old stream are dropped using an epoch bit.
// Optional build macro: CALCU16_FETCH_STATS_EN adds stall_cnt / flush_cnt.
module calcu16_fetch_queue #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 4,
  parameter int RESET_PC = 0
) (
  input  logic clk,
  input  logic rst_n,
  calcu16_fetch_queue_if.master bus
`ifdef CALCU16_FETCH_STATS_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [7:0]  flush_cnt
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0]    DEPTH_C    = (CNT_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] RESET_PC_C = ADDR_W'(RESET_PC);

  logic [ADDR_W-1:0] pc_r;
  logic [CNT_W-1:0]  count_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic              inflight_r;
  logic [ADDR_W-1:0] inflight_addr_r;
  logic              inflight_epoch_r;
  logic              epoch_r;
  logic [DATA_W-1:0] data_mem_r [DEPTH];
  logic [ADDR_W-1:0] pc_mem_r   [DEPTH];

  logic [CNT_W:0]    credit_s;
  logic              issue_s;
  logic              push_s;
  logic              pop_s;
  logic              head_valid_s;

  // Reserved occupancy: stored entries plus the response still in flight.
  assign credit_s     = {1'b0, count_r} + {{CNT_W{1'b0}}, inflight_r};
  assign head_valid_s = (count_r != {CNT_W{1'b0}});

  // Issue / push / pop decisions for this cycle.
  always_comb begin
    issue_s = 1'b0;
    push_s  = 1'b0;
    pop_s   = 1'b0;
    if (!bus.halt && !bus.redirect_valid && (credit_s < DEPTH_C)) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
    // A response from an older epoch, or one arriving while a redirect is
    // being taken, belongs to the discarded stream.
    if (inflight_r && (inflight_epoch_r == epoch_r) && !bus.redirect_valid) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
    if (head_valid_s && bus.instr_ready) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  // The read strobe is forced low while reset is held so the memory sees
  // no request before the first post-reset cycle.
  assign bus.imem_rd     = issue_s & rst_n;
  assign bus.imem_addr   = pc_r;
  assign bus.instr_valid = head_valid_s;
  assign bus.instr       = data_mem_r[rd_ptr_r];
  assign bus.instr_pc    = pc_mem_r[rd_ptr_r];

  // Program counter, epoch and in-flight tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r             <= RESET_PC_C;
      epoch_r          <= 1'b0;
      inflight_r       <= 1'b0;
      inflight_addr_r  <= {ADDR_W{1'b0}};
      inflight_epoch_r <= 1'b0;
    end else begin
      if (bus.redirect_valid) begin
        pc_r    <= bus.redirect_pc;
        epoch_r <= ~epoch_r;
      end else if (issue_s) begin
        pc_r <= pc_r + ADDR_W'(1'b1);
      end
      inflight_r <= issue_s;
      if (issue_s) begin
        inflight_addr_r  <= pc_r;
        inflight_epoch_r <= epoch_r;
      end
    end
  end

  // Prefetch FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        data_mem_r[i] <= {DATA_W{1'b0}};
        pc_mem_r[i]   <= {ADDR_W{1'b0}};
      end
    end else if (bus.redirect_valid) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        data_mem_r[wr_ptr_r] <= bus.imem_rdata;
        pc_mem_r[wr_ptr_r]   <= inflight_addr_r;
        wr_ptr_r             <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1'b1);
        2'b01:   count_r <= count_r - CNT_W'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

`ifdef CALCU16_FETCH_STATS_EN
  // Stall cycles (core ready, nothing to give) and redirect count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 16'h0000;
      flush_cnt <= 8'h00;
    end else if (bus.redirect_valid) begin
      stall_cnt <= 16'h0000;
      flush_cnt <= flush_cnt + 8'h01;
    end else if (bus.instr_ready && !head_valid_s && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'h0001;
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_calcu16_fetch_queue.sv
// Self-checking bench for calcu16_fetch_queue.
// A memory model returns 16'hA000 + address one cycle after each read. The
// stimulus pushes the hand-computed instruction stream into a scoreboard
// queue; a negedge monitor pops and compares on every accepted handshake.
module tb_calcu16_fetch_queue;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  int handshakes = 0;
  logic [23:0] exp_q[$];

  always #5 clk = ~clk;

  calcu16_fetch_queue_if #(.ADDR_W(8), .DATA_W(16)) bus();

`ifdef CALCU16_FETCH_STATS_EN
  logic [15:0] stall_cnt;
  logic [7:0]  flush_cnt;
  calcu16_fetch_queue #(.ADDR_W(8), .DATA_W(16), .DEPTH(4), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));
`else
  calcu16_fetch_queue #(.ADDR_W(8), .DATA_W(16), .DEPTH(4), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  // Synchronous program memory: data one cycle after the read strobe.
  always @(posedge clk) begin
    if (bus.imem_rd) bus.imem_rdata <= 16'hA000 + {8'h00, bus.imem_addr};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_run(input logic [7:0] start, input int n);
    logic [7:0] pc;
    for (int i = 0; i < n; i++) begin
      pc = start + 8'(i);
      exp_q.push_back({pc, 16'hA000 + {8'h00, pc}});
    end
  endtask

  // Scoreboard monitor: compare every accepted instruction.
  always @(negedge clk) begin
    logic [23:0] e;
    if (rst_n && bus.instr_valid && bus.instr_ready) begin
      handshakes++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_instr: got pc %h instr %h expected none", bus.instr_pc, bus.instr);
      end else begin
        e = exp_q.pop_front();
        check("instr_stream", {8'h00, bus.instr_pc, bus.instr}, {8'h00, e});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Hold ready until n more instructions are accepted; report cycles used.
  task automatic consume(input int n, input string name, output int cycles);
    int target;
    target = handshakes + n;
    cycles = 0;
    bus.instr_ready = 1'b1;
    while (handshakes < target && cycles < 60) begin
      cyc();
      cycles++;
    end
    bus.instr_ready = 1'b0;
    if (handshakes < target) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: got %0d handshakes expected %0d", name, handshakes, target);
    end
  endtask

  initial begin
    int pulses;
    int cycles;
    bus.instr_ready    = 1'b0;
    bus.halt           = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 8'h00;
    bus.imem_rdata     = 16'h0000;
    rst_n = 1'b0;
    repeat (3) cyc();
    #1;
    check("rst_imem_rd", {31'd0, bus.imem_rd}, 32'd0);
    check("rst_imem_addr", {24'd0, bus.imem_addr}, 32'd0);
    check("rst_instr_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("rst_instr", {16'd0, bus.instr}, 32'd0);
    check("rst_instr_pc", {24'd0, bus.instr_pc}, 32'd0);

    // Back-pressure after reset: exactly four reads, addresses 0..3.
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (bus.imem_rd) begin
        check("burst_addr", {24'd0, bus.imem_addr}, pulses);
        pulses++;
      end
      cyc();
    end
    #1;
    check("burst_pulses", pulses, 32'd4);
    check("full_no_rd", {31'd0, bus.imem_rd}, 32'd0);
    check("full_valid", {31'd0, bus.instr_valid}, 32'd1);
    check("full_head_instr", {16'd0, bus.instr}, 32'h0000A000);
    check("full_head_pc", {24'd0, bus.instr_pc}, 32'd0);
    expect_run(8'h00, 8);
    consume(8, "drain", cycles);
    check("drain_no_gap_cycles", cycles, 32'd8);

    // Redirect with three entries stored and one read outstanding.
    cyc();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 8'h40;
    #1;
    check("redirect_no_issue", {31'd0, bus.imem_rd}, 32'd0);
    cyc();
    bus.redirect_valid = 1'b0;
    #1;
    check("redirect_flushed", {31'd0, bus.instr_valid}, 32'd0);
    check("redirect_issue", {31'd0, bus.imem_rd}, 32'd1);
    check("redirect_addr", {24'd0, bus.imem_addr}, 32'h40);
    expect_run(8'h40, 4);
    consume(4, "redirect_stream", cycles);
    check("redirect_latency_cycles", cycles, 32'd6);

    // Address wrap from 0xFE.
    cyc();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 8'hFE;
    cyc();
    bus.redirect_valid = 1'b0;
    expect_run(8'hFE, 4);
    consume(4, "wrap_stream", cycles);
    check("wrap_latency_cycles", cycles, 32'd6);

    // Halt mid-stream for five cycles.
    cyc();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 8'h10;
    expect_run(8'h10, 4);
    cyc();
    bus.redirect_valid = 1'b0;
    bus.instr_ready    = 1'b1;
    repeat (4) cyc();
    bus.halt = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("halt_no_rd", {31'd0, bus.imem_rd}, 32'd0);
      cyc();
    end
    #1;
    check("halt_drained", {31'd0, bus.instr_valid}, 32'd0);
    check("halt_inflight_pushed", exp_q.size(), 32'd0);
    bus.halt = 1'b0;
    #1;
    check("halt_resume_rd", {31'd0, bus.imem_rd}, 32'd1);
    check("halt_resume_addr", {24'd0, bus.imem_addr}, 32'h14);
    expect_run(8'h14, 4);
    consume(4, "halt_resume_stream", cycles);
    check("halt_resume_cycles", cycles, 32'd6);

    // Reset pulse with a read outstanding.
    cyc();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 8'h20;
    expect_run(8'h20, 2);
    cyc();
    bus.redirect_valid = 1'b0;
    bus.instr_ready    = 1'b1;
    repeat (4) cyc();
    rst_n = 1'b0;
    #1;
    check("midrst_imem_rd", {31'd0, bus.imem_rd}, 32'd0);
    check("midrst_imem_addr", {24'd0, bus.imem_addr}, 32'd0);
    check("midrst_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("midrst_instr", {16'd0, bus.instr}, 32'd0);
    check("midrst_instr_pc", {24'd0, bus.instr_pc}, 32'd0);
    check("midrst_prior_stream", exp_q.size(), 32'd0);
    repeat (2) cyc();
    expect_run(8'h00, 4);
    rst_n = 1'b1;
    consume(4, "post_reset_stream", cycles);
    check("post_reset_latency_cycles", cycles, 32'd6);

    cyc();
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
